// File: rtl/pia_kbd_pkg.sv
// Apple-1 PIA keyboard port: shared address map, handshake state encoding and key width.
// Address defines are guarded so the display port can provide the same map without a clash.
`ifndef PIA_KBD_REG
`define PIA_KBD_REG 16'hD010
`endif
`ifndef PIA_KBD_CR
`define PIA_KBD_CR 16'hD011
`endif

package pia_kbd_pkg;

    localparam int KEY_W = 7;

    typedef logic [KEY_W-1:0] key_t;

    // One-hot host handshake states
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ACK  = 3'b010,
        S_REL  = 3'b100
    } hs_state_t;

endpackage

// File: rtl/pia_kbd_fifo.sv
// Key buffer: FIFO_DEPTH entries of 7-bit ASCII, head visible combinationally on dout.
// Latency: a push is visible on dout the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
module pia_kbd_fifo
    import pia_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  key_t       din,
    output key_t       dout,
    output logic       empty,
    output logic       full
);

    key_t               mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pia_kbd.sv
// Apple-1 PIA keyboard port (KBD/KBDCR) with 4-phase host strobe/ack into a key FIFO.
// Latency: kbd_ack one cycle after strobe; key readable the cycle after capture; one pop per read access.
// Backpressure: strobe left unacked while FIFO full. Option: KBD_UPCASE_EN folds lower case and DEL.
module pia_kbd
    import pia_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Address_Bus,
    input  logic        WE,
    output logic [7:0]  Data_Out,
    input  logic        kbd_stb,
    input  logic [6:0]  kbd_data,
    output logic        kbd_ack,
    output logic        kbd_full
);

    hs_state_t state;
    logic      rd_kbd;
    logic      rd_q;
    logic      push;
    logic      pop;
    logic      empty;
    logic      full;
    key_t      head;
    key_t      key_in;

    assign rd_kbd   = (Address_Bus == `PIA_KBD_REG) && !WE;
    assign pop      = rd_kbd && !rd_q;
    assign push     = (state == S_IDLE) && kbd_stb && !full;
    assign kbd_full = full;

`ifdef KBD_UPCASE_EN
    always_comb begin
        key_in = kbd_data;
        if (kbd_data >= 7'h61 && kbd_data <= 7'h7A) begin
            key_in = kbd_data - 7'h20;
        end else if (kbd_data == 7'h7F) begin
            key_in = 7'h5F;
        end
    end
`else
    assign key_in = kbd_data;
`endif

    pia_kbd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (key_in),
        .dout  (head),
        .empty (empty),
        .full  (full)
    );

    // Host handshake: one key per strobe pulse, ack held until strobe drops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            kbd_ack <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            rd_q <= rd_kbd;
            case (state)
                S_IDLE: begin
                    if (push) begin
                        kbd_ack <= 1'b1;
                        state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!kbd_stb) begin
                        kbd_ack <= 1'b0;
                        state   <= S_REL;
                    end
                end
                S_REL: begin
                    state <= S_IDLE;
                end
                default: begin
                    kbd_ack <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Data_Out = 8'h00;
        if (Address_Bus == `PIA_KBD_REG) begin
            if (!empty) begin
                Data_Out = {1'b1, head};
            end
        end else if (Address_Bus == `PIA_KBD_CR) begin
            Data_Out = {~empty, 7'b0};
        end
    end

endmodule

// File: tb/tb_pia_kbd.sv
// Bench for pia_kbd: queue-based model checked every cycle plus directed literal expectations.
module tb_pia_kbd;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] Address_Bus;
    logic        WE;
    logic [7:0]  Data_Out;
    logic        kbd_stb;
    logic [6:0]  kbd_data;
    logic        kbd_ack;
    logic        kbd_full;

    int checks = 0;
    int errors = 0;

    pia_kbd #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .Address_Bus (Address_Bus),
        .WE          (WE),
        .Data_Out    (Data_Out),
        .kbd_stb     (kbd_stb),
        .kbd_data    (kbd_data),
        .kbd_ack     (kbd_ack),
        .kbd_full    (kbd_full)
    );

    always #5 clk = ~clk;

`ifdef KBD_UPCASE_EN
    localparam bit UP = 1'b1;
`else
    localparam bit UP = 1'b0;
`endif

    function automatic logic [6:0] map_key(input logic [6:0] k);
        if (UP && k >= 7'h61 && k <= 7'h7A) return k - 7'h20;
        if (UP && k == 7'h7F) return 7'h5F;
        return k;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a key queue, a handshake phase (0 idle, 1 acked, 2 release) and read-edge memory
    logic [6:0] m_q[$];
    int         m_phase;
    bit         m_prev_rd;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_phase   = 0;
            m_prev_rd = 0;
        end else begin
            bit rd, pop, push;
            rd   = (Address_Bus == 16'hD010) && !WE;
            pop  = rd && !m_prev_rd && (m_q.size() > 0);
            push = (m_phase == 0) && kbd_stb && (m_q.size() < 4);
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(map_key(kbd_data));
            case (m_phase)
                0: if (push) m_phase = 1;
                1: if (!kbd_stb) m_phase = 2;
                default: m_phase = 0;
            endcase
            m_prev_rd = rd;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            logic [7:0] exp_d;
            exp_d = 8'h00;
            if (Address_Bus == 16'hD010 && m_q.size() > 0) exp_d = {1'b1, m_q[0]};
            else if (Address_Bus == 16'hD011) exp_d = {m_q.size() > 0, 7'b0};
            chk("model_dout", Data_Out, exp_d);
            chk("model_ack", {7'b0, kbd_ack}, {7'b0, m_phase == 1});
            chk("model_full", {7'b0, kbd_full}, {7'b0, m_q.size() == 4});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string name);
        int n = 0;
        while (kbd_ack !== v && n < 20) begin
            tick();
            n++;
        end
        if (kbd_ack !== v) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, ack %b expected %b", name, kbd_ack, v);
        end
    endtask

    task automatic host_key(input logic [6:0] k);
        kbd_data = k;
        kbd_stb  = 1'b1;
        wait_ack(1'b1, "ack_rise");
        kbd_stb = 1'b0;
        wait_ack(1'b0, "ack_fall");
        tick();
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input string name);
        Address_Bus = a;
        WE          = 1'b0;
        #1;
        chk(name, Data_Out, exp);
        tick();
        Address_Bus = 16'h0000;
        tick();
    endtask

    initial begin
        reset       = 1'b0;
        Address_Bus = 16'hD011;
        WE          = 1'b0;
        kbd_stb     = 1'b0;
        kbd_data    = 7'h00;
        #1;
        chk("rst_ack", {7'b0, kbd_ack}, 8'h00);
        chk("rst_full", {7'b0, kbd_full}, 8'h00);
        chk("rst_kbdcr", Data_Out, 8'h00);
        Address_Bus = 16'h0000;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // 1: single key
        kbd_data = 7'h41;
        kbd_stb  = 1'b1;
        tick();
        chk("t1_ack", {7'b0, kbd_ack}, 8'h01);
        kbd_stb = 1'b0;
        wait_ack(1'b0, "t1_ack_fall");
        tick();
        cpu_read(16'hD011, 8'h80, "t1_kbdcr");
        cpu_read(16'hD010, 8'hC1, "t1_kbd");
        cpu_read(16'hD011, 8'h00, "t1_kbdcr_empty");

        // 2: fill, fifth strobe stalls until a read frees a slot
        for (int i = 0; i < 4; i++) host_key(7'(8'h41 + i));
        chk("t2_full", {7'b0, kbd_full}, 8'h01);
        kbd_data = 7'h45;
        kbd_stb  = 1'b1;
        repeat (3) tick();
        chk("t2_no_ack", {7'b0, kbd_ack}, 8'h00);
        cpu_read(16'hD010, 8'hC1, "t2_rd0");
        chk("t2_late_ack", {7'b0, kbd_ack}, 8'h01);
        kbd_stb = 1'b0;
        wait_ack(1'b0, "t2_ack_fall");
        tick();
        for (int i = 1; i < 5; i++) cpu_read(16'hD010, 8'hC1 + 8'(i), "t2_rd");
        cpu_read(16'hD011, 8'h00, "t2_empty");

        // 3: held read pops once; writes are ignored
        host_key(7'h46);
        host_key(7'h47);
        Address_Bus = 16'hD010;
        WE          = 1'b0;
        #1;
        chk("t3_head", Data_Out, 8'hC6);
        repeat (4) tick();
        Address_Bus = 16'h0000;
        tick();
        cpu_read(16'hD011, 8'h80, "t3_kbdcr");
        Address_Bus = 16'hD010;
        WE          = 1'b1;
        tick();
        WE          = 1'b0;
        Address_Bus = 16'h0000;
        tick();
        cpu_read(16'hD010, 8'hC7, "t3_after_write");
        cpu_read(16'hD011, 8'h00, "t3_empty");

        // 4: push and pop on the same edge
        host_key(7'h48);
        host_key(7'h49);
        kbd_data    = 7'h4A;
        kbd_stb     = 1'b1;
        Address_Bus = 16'hD010;
        WE          = 1'b0;
        #1;
        chk("t4_old_head", Data_Out, 8'hC8);
        tick();
        Address_Bus = 16'h0000;
        chk("t4_ack", {7'b0, kbd_ack}, 8'h01);
        kbd_stb = 1'b0;
        wait_ack(1'b0, "t4_ack_fall");
        tick();
        cpu_read(16'hD010, 8'hC9, "t4_rd1");
        cpu_read(16'hD010, 8'hCA, "t4_rd2");
        cpu_read(16'hD011, 8'h00, "t4_empty");

        // 5: reset mid-handshake, strobe still high afterwards
        host_key(7'h4B);
        host_key(7'h4C);
        host_key(7'h4D);
        kbd_data = 7'h4E;
        kbd_stb  = 1'b1;
        tick();
        chk("t5_ack", {7'b0, kbd_ack}, 8'h01);
        reset = 1'b0;
        #1;
        chk("t5_ack_drop", {7'b0, kbd_ack}, 8'h00);
        Address_Bus = 16'hD011;
        #1;
        chk("t5_kbdcr", Data_Out, 8'h00);
        Address_Bus = 16'h0000;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("t5_recapture", {7'b0, kbd_ack}, 8'h01);
        kbd_stb = 1'b0;
        wait_ack(1'b0, "t5_ack_fall");
        tick();
        cpu_read(16'hD010, 8'hCE, "t5_rd");
        cpu_read(16'hD011, 8'h00, "t5_empty");

        // 6: case folding option
        host_key(7'h61);
        cpu_read(16'hD010, UP ? 8'hC1 : 8'hE1, "t6_lower_a");
        host_key(7'h7F);
        cpu_read(16'hD010, UP ? 8'hDF : 8'hFF, "t6_del");
        cpu_read(16'hD011, 8'h00, "t6_empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
